// File: rtl/select_first_stream_pkg.sv
// Shared types and helpers for the registered select-first stream arbiter.
package select_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Index width for n channels, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Sign- or zero-extend the low in_w bits of data to MAX_W bits.
  function automatic logic [MAX_W-1:0] ext(input logic [MAX_W-1:0] data,
                                           input int in_w,
                                           input logic signed_en);
    logic [MAX_W-1:0] r;
    r = data;
    for (int i = 0; i < MAX_W; i++) begin
      if (signed_en && i >= in_w) r[i] = data[in_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/select_first_stream_prio_pick.sv
// Priority picker: first requester found scanning upward from a start pointer, with wrap.
module prio_pick
  import select_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int RR_MODE = 0,
  localparam int CW      = ch_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  idx,
  output logic           any
);

  logic [CW-1:0] start;

  assign start = (RR_MODE != 0) ? ptr : '0;

  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    int            c;
    logic [CW-1:0] ci;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < NCH; k++) begin
      c = int'(start) + k;
      if (c >= NCH) c = c - NCH;
      ci = CW'(c);
      if (!any && req[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/select_first_stream.sv
// Selects one of NCH valid/ready streams into a single registered output beat,
// with fixed-priority or round-robin arbitration and optional packet lock.
module select_first_stream
  import select_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int IN_W    = 8,
  parameter  int OUT_W   = 11,
  parameter  int SIGNED  = 0,
  parameter  int RR_MODE = 0,
  parameter  int LOCK    = 0,
  localparam int CW      = ch_w(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*IN_W-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [CW-1:0]     out_ch
);

  if (OUT_W < IN_W || OUT_W > MAX_W || NCH < 2 || NCH > 16) begin : g_bad_params
    $error("select_first_stream: illegal NCH/IN_W/OUT_W combination");
  end

  lock_state_t   state;
  logic [CW-1:0] lock_ch;
  logic [CW-1:0] ptr;
  logic [CW-1:0] idx;
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;
  logic           any;
  logic           load_en;
  logic           accept;
  logic           win_last;
  logic [IN_W-1:0] win_data;

  assign load_en = !out_valid || out_ready;

  // While locked only the owning channel may compete; a bubble there stalls everything.
  assign req = (LOCK != 0 && state == LOCKED) ? (in_valid & (NCH'(1) << lock_ch)) : in_valid;

  prio_pick #(
    .NCH     (NCH),
    .RR_MODE (RR_MODE)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign in_ready = load_en ? grant : '0;
  assign accept   = load_en && any;
  assign win_last = |(in_last & grant);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) win_data = in_data[i*IN_W +: IN_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= any;
      if (any) begin
        out_data <= OUT_W'(ext(MAX_W'(win_data), IN_W, SIGNED != 0));
        out_last <= win_last;
        out_ch   <= idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      state   <= IDLE;
      lock_ch <= '0;
    end else if (accept) begin
      if (RR_MODE != 0 && (LOCK == 0 || win_last)) begin
        ptr <= (idx == CW'(NCH - 1)) ? '0 : idx + 1'b1;
      end
      if (LOCK != 0) begin
        if (state == IDLE && !win_last) begin
          state   <= LOCKED;
          lock_ch <= idx;
        end else if (state == LOCKED && win_last) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_select_first_stream.sv
// Drives four arbiter configurations from shared stimulus and checks them against
// a behavioural model plus directed vectors and corner-case sequences.
module tb_select_first_stream;

  localparam int NC = 4;
  // cfg0: fixed/zero-ext, cfg1: fixed/sign-ext, cfg2: RR/zero-ext, cfg3: RR/sign-ext/lock
  localparam logic [3:0] SGN_M = 4'b1010;
  localparam logic [3:0] RR_M  = 4'b1100;
  localparam logic [3:0] LK_M  = 4'b1000;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [3:0]  in_valid  = '0;
  logic [3:0]  in_last   = '0;
  logic [31:0] in_data   = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  rdy [NC];
  logic        ov  [NC];
  logic [10:0] od  [NC];
  logic        ol  [NC];
  logic [1:0]  oc  [NC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    select_first_stream #(
      .NCH     (4),
      .IN_W    (8),
      .OUT_W   (11),
      .SIGNED  (int'(SGN_M[g])),
      .RR_MODE (int'(RR_M[g])),
      .LOCK    (int'(LK_M[g]))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .out_last  (ol[g]),
      .out_ch    (oc[g])
    );
  end

  // Reference model state per configuration.
  bit          m_ov   [NC];
  logic [10:0] m_od   [NC];
  bit          m_ol   [NC];
  int          m_oc   [NC];
  int          m_ptr  [NC];
  bit          m_lock [NC];
  int          m_lch  [NC];

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cfg%0d got=%0h want=%0h at %0t", name, c, act, exp_v, $time);
    end
  endtask

  function automatic logic [10:0] mext(input int c, input logic [7:0] d);
    return SGN_M[c] ? {{3{d[7]}}, d} : {3'b000, d};
  endfunction

  // Winning channel under the arbitration rules, or -1 when nobody may go.
  function automatic int pick(input int c);
    int s;
    if (m_lock[c]) return in_valid[m_lch[c]] ? m_lch[c] : -1;
    s = RR_M[c] ? m_ptr[c] : 0;
    for (int k = 0; k < NC; k++) begin
      if (in_valid[(s + k) % NC]) return (s + k) % NC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_ov[c] = 0; m_od[c] = '0; m_ol[c] = 0; m_oc[c] = 0;
      m_ptr[c] = 0; m_lock[c] = 0; m_lch[c] = 0;
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    int w  [NC];
    bit le [NC];
    bit lst;
    #1;
    for (int c = 0; c < NC; c++) begin
      w[c]  = pick(c);
      le[c] = !m_ov[c] || out_ready;
      check("in_ready", c, 32'(rdy[c]), (le[c] && w[c] >= 0) ? (32'd1 << w[c]) : 32'd0);
    end
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (le[c]) begin
        m_ov[c] = (w[c] >= 0);
        if (w[c] >= 0) begin
          lst     = in_last[w[c]];
          m_od[c] = mext(c, in_data[w[c]*8 +: 8]);
          m_ol[c] = lst;
          m_oc[c] = w[c];
          if (RR_M[c] && (!LK_M[c] || lst)) m_ptr[c] = (w[c] + 1) % NC;
          if (LK_M[c]) begin
            if (!m_lock[c] && !lst) begin
              m_lock[c] = 1;
              m_lch[c]  = w[c];
            end else if (m_lock[c] && lst) begin
              m_lock[c] = 0;
            end
          end
        end
      end
    end
    #1;
    for (int c = 0; c < NC; c++) begin
      check("out_valid", c, 32'(ov[c]), 32'(m_ov[c]));
      check("out_data",  c, 32'(od[c]), 32'(m_od[c]));
      check("out_last",  c, 32'(ol[c]), 32'(m_ol[c]));
      check("out_ch",    c, 32'(oc[c]), 32'(m_oc[c]));
    end
  endtask

  task automatic do_reset();
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      check("rst_out_valid", c, 32'(ov[c]), 32'd0);
      check("rst_out_data",  c, 32'(od[c]), 32'd0);
      check("rst_out_last",  c, 32'(ol[c]), 32'd0);
      check("rst_out_ch",    c, 32'(oc[c]), 32'd0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  ch;
    logic [10:0] d0;
    logic [10:0] d1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    // Fixed priority, out_ready=1; d0 is the zero-extended and d1 the sign-extended result.
    tbl[0] = '{v: 4'b1010, d: 8'h80, rdy: 4'b0010, ov: 1'b1, ch: 2'd1, d0: 11'h080, d1: 11'h780};
    tbl[1] = '{v: 4'b0000, d: 8'h11, rdy: 4'b0000, ov: 1'b0, ch: 2'd1, d0: 11'h080, d1: 11'h780};
    tbl[2] = '{v: 4'b1111, d: 8'h7F, rdy: 4'b0001, ov: 1'b1, ch: 2'd0, d0: 11'h07F, d1: 11'h07F};
    tbl[3] = '{v: 4'b1000, d: 8'hFF, rdy: 4'b1000, ov: 1'b1, ch: 2'd3, d0: 11'h0FF, d1: 11'h7FF};
    tbl[4] = '{v: 4'b0110, d: 8'h01, rdy: 4'b0010, ov: 1'b1, ch: 2'd1, d0: 11'h001, d1: 11'h001};
    tbl[5] = '{v: 4'b0100, d: 8'hC3, rdy: 4'b0100, ov: 1'b1, ch: 2'd2, d0: 11'h0C3, d1: 11'h7C3};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      in_valid  = tbl[i].v;
      in_data   = {4{tbl[i].d}};
      in_last   = '0;
      out_ready = 1'b1;
      #1;
      check("tbl_ready", 0, 32'(rdy[0]), 32'(tbl[i].rdy));
      step();
      check("tbl_valid", 0, 32'(ov[0]), 32'(tbl[i].ov));
      check("tbl_ch",    0, 32'(oc[0]), 32'(tbl[i].ch));
      check("tbl_zext",  0, 32'(od[0]), 32'(tbl[i].d0));
      check("tbl_sext",  1, 32'(od[1]), 32'(tbl[i].d1));
    end

    // Round-robin with every channel requesting.
    do_reset();
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      step();
      check("rr_seq", 2, 32'(oc[2]), 32'(i % 4));
      check("rr_seq", 3, 32'(oc[3]), 32'(i % 4));
    end

    // Backpressure: held beat stays put, then one beat per cycle on release.
    do_reset();
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = 32'h44332211;
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 0, 32'(rdy[0]), 32'd0);
      step();
      check("bp_valid", 0, 32'(ov[0]), 32'd1);
      check("bp_data",  0, 32'(od[0]), 32'h011);
      check("bp_ch",    0, 32'(oc[0]), 32'd0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {24'h443322, 8'(8'h30 + i)};
      #1;
      check("rel_ready", 0, 32'(rdy[0]), 32'd1);
      step();
      check("rel_valid", 0, 32'(ov[0]), 32'd1);
      check("rel_data",  0, 32'(od[0]), 32'(8'h30 + i));
    end

    // Packet lock on ch2 with a mid-packet bubble while ch0 is waiting.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0100; in_last = 4'b0000; in_data = 32'h00A10055;
    step();
    check("lk_b1_ch", 3, 32'(oc[3]), 32'd2);
    in_valid  = 4'b0101; in_last = 4'b0001; in_data = 32'h00A20055;
    #1;
    check("lk_b2_ready", 3, 32'(rdy[3]), 32'b0100);
    step();
    check("lk_b2_ch", 3, 32'(oc[3]), 32'd2);
    in_valid  = 4'b0001;
    #1;
    check("lk_bubble_ready", 3, 32'(rdy[3]), 32'd0);
    step();
    check("lk_bubble_valid", 3, 32'(ov[3]), 32'd0);
    in_valid  = 4'b0101; in_last = 4'b0101; in_data = 32'h00A30055;
    #1;
    check("lk_b3_ready", 3, 32'(rdy[3]), 32'b0100);
    step();
    check("lk_b3_ch",   3, 32'(oc[3]), 32'd2);
    check("lk_b3_last", 3, 32'(ol[3]), 32'd1);
    check("lk_b3_data", 3, 32'(od[3]), 32'h7A3);
    in_valid  = 4'b0001;
    #1;
    check("lk_after_ready", 3, 32'(rdy[3]), 32'd1);
    step();
    check("lk_after_ch", 3, 32'(oc[3]), 32'd0);

    // Reset in the middle of a locked packet with a beat pending.
    in_valid  = 4'b0100; in_last = 4'b0000; in_data = 32'h00B10066;
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    step();
    do_reset();
    in_valid  = 4'b1111; in_last = 4'b0000; in_data = 32'h0D0C0B0A;
    out_ready = 1'b1;
    #1;
    check("postrst_ready", 0, 32'(rdy[0]), 32'd1);
    check("postrst_ready", 3, 32'(rdy[3]), 32'd1);
    step();
    check("postrst_ch",    0, 32'(oc[0]), 32'd0);
    check("postrst_valid", 0, 32'(ov[0]), 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
